// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART serial receiver. Synchronizes the asynchronous line,
//             detects the start edge, samples each bit once at mid-bit and
//             reports each byte with a one-cycle valid strobe. A low stop bit
//             raises a one-cycle framing-error strobe, after which the
//             receiver waits for the line to return high before re-arming.
//  Ports    : clk       - system clock
//             rst_n     - asynchronous active-low reset
//             rx_line   - asynchronous serial input, idle high
//             rx_data   - last correctly received byte (LSB first on wire)
//             rx_valid  - one-cycle pulse, rx_data holds a new byte
//             frame_err - one-cycle pulse, stop bit was sampled low
//             rx_busy   - high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    // Mid-start-bit offset is always derived from the bit period.
    localparam int HALF_BIT = CLK_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLK_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    if (CLK_PER_BIT < 4) begin : g_bad_clk_per_bit
        $error("uart_rx: CLK_PER_BIT must be at least 4");
    end

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] clk_count;
    logic [2:0]       bit_index;
    logic [7:0]       shift_reg;
    logic [CNT_W-1:0] count_last;
    logic             terminal;

    // Two-flop synchronizer; flops reset to the idle (high) line level so a
    // reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_s    <= rx_meta;
        end
    end

    // The start state only counts half a bit so that every later terminal
    // cycle lands in the middle of a bit cell.
    always_comb begin
        count_last = (state == START) ? HALF_LAST : BIT_LAST;
        terminal   = (clk_count == count_last);
    end

    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_count <= '0;
            bit_index <= 3'd0;
            shift_reg <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    clk_count <= '0;
                    bit_index <= 3'd0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end

                START: begin
                    if (terminal) begin
                        clk_count <= '0;
                        if (!rx_s) begin
                            state     <= DATA;
                            bit_index <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            state <= IDLE;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                DATA: begin
                    if (terminal) begin
                        clk_count            <= '0;
                        shift_reg[bit_index] <= rx_s;
                        // Leave before incrementing so the 3-bit index never wraps.
                        if (bit_index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_index <= bit_index + 3'd1;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                STOP: begin
                    if (terminal) begin
                        clk_count <= '0;
                        if (rx_s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end

                BREAK: begin
                    // A held-low line must not be decoded as repeated 0x00
                    // frames; wait for the line to return to idle first.
                    clk_count <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    clk_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
